spi_slave_param: RTL
====================

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16: bits per SPI word.
REQ-002 SHALL have parameter CPOL, default 0: SCLK idle level.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on first edge, 1 = sample on second edge.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, minimum 2: synchroniser depth on i_cs, i_sclk and i_mosi.
REQ-005 SHALL have parameter CH_NUM, default 32: words per frame before channel_num wraps; CH_W = clog2(CH_NUM).
REQ-006 SHALL have port i_clk, input, 1: the only clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port i_cs, input, 1: chip select, active-low, asynchronous to i_clk.
REQ-009 SHALL have port i_sclk, input, 1: SPI clock, asynchronous to i_clk.
REQ-010 SHALL have port i_mosi, input, 1: serial data in, MSB first.
REQ-011 SHALL have port o_miso, output, 1: serial data out, MSB first.
REQ-012 SHALL have port data_in, input, DATA_W: transmit word, captured at each word load.
REQ-013 SHALL have port rec_data, output, DATA_W: last complete received word.
REQ-014 SHALL have port rec_done, output, 1: one-cycle pulse when rec_data updates.
REQ-015 SHALL have port transmit_done, output, 1: one-cycle pulse when the last bit of a transmit word is shifted out.
REQ-016 SHALL have port channel_num, output, CH_W: index of the current word within the frame.
REQ-017 SHALL have port frame_err, output, 1: one-cycle pulse when i_cs rises mid-word.

Function
REQ-018 SHALL detect edges on the synchronised SCLK only; sample edge = rising if CPOL==CPHA, else falling; shift edge = the opposite edge.
REQ-019 SHALL implement FSM IDLE -> LOAD -> SHIFT -> IDLE.
REQ-020 IDLE SHALL go to LOAD on synchronised i_cs falling.
REQ-021 LOAD SHALL capture data_in, drive its MSB on o_miso, clear the bit counter, then go to SHIFT after one cycle.
REQ-022 SHIFT SHALL shift i_mosi into the receive register on each sample edge and advance o_miso on each shift edge.
REQ-023 With CPHA=1, SHIFT SHALL skip the first shift edge of each word, so MSB stays driven until it is sampled.
REQ-024 After the DATA_W-th sample, SHALL load rec_data in the next cycle and pulse rec_done for 1 cycle; latency is 1 i_clk after the synchronised sample edge.
REQ-025 transmit_done SHALL pulse in the same cycle as rec_done.
REQ-026 At word end with i_cs still low, SHALL increment channel_num, recapture data_in, and stay in SHIFT with no idle gap.
REQ-027 channel_num SHALL wrap from CH_NUM-1 to 0.
REQ-028 channel_num SHALL clear when i_cs is deasserted.
REQ-029 On i_cs rising with bit counter nonzero: pulse frame_err; do not pulse rec_done; leave rec_data unchanged; go to IDLE.
REQ-030 On i_cs rising with bit counter zero: go to IDLE silently.
REQ-031 o_miso SHALL be 0 in IDLE.
REQ-032 Minimum SCLK half-period SHALL be SYNC_STAGES+2 i_clk cycles; behaviour below that is undefined.
REQ-033 If an SCLK edge and i_cs rising arrive in the same cycle, i_cs rising SHALL take priority.

Reset
REQ-034 On i_rst, SHALL set FSM to IDLE.
REQ-035 On i_rst, SHALL clear rec_data, the receive register, the bit counter and channel_num.
REQ-036 On i_rst, SHALL drive o_miso, rec_done, transmit_done and frame_err to 0.
REQ-037 On i_rst, SHALL preset synchronisers to idle: cs=1, sclk=CPOL.
REQ-038 Reset mid-word SHALL abort the word with no pulses.
REQ-039 After reset release, SHALL wait for a fresh i_cs falling edge before starting a frame.

Configuration
REQ-040 Macro SPI_SLAVE_ECHO_EN defined: each LOAD SHALL transmit the previous rec_data instead of data_in (loopback test mode); data_in is ignored.
REQ-041 Macro SPI_SLAVE_ECHO_EN undefined: SHALL transmit data_in and contain no echo mux.

Structure
REQ-042 Package spi_pkg SHALL hold the FSM state enum, the mode encoding (CPOL/CPHA to sample-edge select), and the default DATA_W and CH_NUM constants.
REQ-043 Sub-module spi_sync_edge SHALL hold the SYNC_STAGES synchroniser plus rise/fall detect, instanced once per input.

Verification
REQ-044 Mode 0, DATA_W=16, MOSI 16'hF001 in one frame -> rec_data=16'hF001, one rec_done pulse, channel_num=0.
REQ-045 data_in=16'h07CB, mode 0 -> o_miso sampled on rising SCLK reads 16'h07CB MSB first; transmit_done coincides with rec_done.
REQ-046 4 words under one CS; bench adds 16'hA177 to data_in on each rec_done -> MISO words 07CB, A942, 4AB9, EC30; channel_num 0,1,2,3, then 0 after CS high.
REQ-047 CS raised after 7 bits -> frame_err pulses once; no rec_done; rec_data holds its prior value.
REQ-048 Mode 3 (CPOL=1, CPHA=1), MOSI 16'h5A3C -> rec_data=16'h5A3C; i_rst asserted mid-word in a second frame -> all outputs 0, no pulses.
REQ-049 SPI_SLAVE_ECHO_EN defined: word 16'h1234 followed by a second word -> MISO returns 16'h1234 during the second word.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the parameterised SPI slave.
// Holds the FSM state encoding, the SPI mode encoding with a helper that
// maps CPOL/CPHA to the sample-edge polarity, and default sizing constants.
package spi_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_CH_NUM = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_state_e;

  // Mode number is {CPOL, CPHA}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  function automatic spi_mode_e mode_of(input logic cpol, input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

  // Data is sampled on the rising SCLK edge when CPOL == CPHA
  function automatic logic sample_on_rise(input spi_mode_e mode);
    return (mode == MODE0) || (mode == MODE3);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge -- multi-stage synchroniser with rise/fall detection.
// Ports:
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset, presets every stage to RESET_VAL
//   i_async  : asynchronous input
//   o_sync   : synchronised level
//   o_rise   : one-cycle pulse on a synchronised 0->1 transition
//   o_fall   : one-cycle pulse on a synchronised 1->0 transition
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the raw input through the chain; prev holds the last settled level
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_async};
    prev_d = sync_q[STAGES-1];
  end

  // Reset presets to the idle level so no spurious edge appears on reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_sync = sync_q[STAGES-1];
  assign o_rise = o_sync & ~prev_q;
  assign o_fall = ~o_sync & prev_q;

endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param -- parameterised SPI slave running entirely on i_clk.
// Ports:
//   i_clk, i_rst       : system clock, synchronous active-high reset
//   i_cs, i_sclk, i_mosi : asynchronous SPI inputs (cs active-low)
//   o_miso             : serial data out, MSB first, 0 while idle
//   data_in            : transmit word, captured at every word load
//   rec_data, rec_done : last received word and its one-cycle strobe
//   transmit_done      : strobe when a transmit word has been shifted out
//   channel_num        : index of the current word in the frame
//   frame_err          : strobe when chip select rises mid-word
// Build option: define SPI_SLAVE_ECHO_EN to transmit the previously
// received word instead of data_in (loopback test mode).
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int CH_NUM      = DEFAULT_CH_NUM
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cs,
  input  logic                      i_sclk,
  input  logic                      i_mosi,
  output logic                      o_miso,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W-1:0]         rec_data,
  output logic                      rec_done,
  output logic                      transmit_done,
  output logic [$clog2(CH_NUM)-1:0] channel_num,
  output logic                      frame_err
);

  localparam int   CH_W        = $clog2(CH_NUM);
  localparam int   CNT_W       = $clog2(DATA_W);
  localparam int   WARM_W      = $clog2(SYNC_STAGES + 2);
  localparam logic SAMPLE_RISE = sample_on_rise(mode_of(CPOL != 0, CPHA != 0));

  logic cs_s, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_cs),
    .o_sync(cs_s), .o_rise(cs_rise), .o_fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL != 0)) u_sync_sclk (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_sclk),
    .o_sync(sclk_lvl_unused), .o_rise(sclk_rise), .o_fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst(i_rst), .i_async(i_mosi),
    .o_sync(mosi_s), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused)
  );

  logic sample_edge, shift_edge;
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rec_data_q, rec_data_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic              armed_q, armed_d;
  logic              miso_q, miso_d, rec_done_q, rec_done_d;
  logic              tx_done_q, tx_done_d, frame_err_q, frame_err_d;
  logic [DATA_W-1:0] tx_src;
  logic              warm_done;

`ifdef SPI_SLAVE_ECHO_EN
  logic unused_data_in;
  assign unused_data_in = ^data_in;
  assign tx_src         = rec_data_q;
`else
  assign tx_src = data_in;
`endif

  // The synchronisers hold their preset idle level for a few cycles after
  // reset; a chip select that is already low must not look like a fresh
  // falling edge, so frames are only accepted once cs has been seen high.
  assign warm_done = (warm_q == WARM_W'(SYNC_STAGES + 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; chip select rising always wins over SCLK activity
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall && armed_q) state_d = LOAD;
      LOAD:    state_d = cs_rise ? IDLE : SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output strobes. A shift edge that arrives before the first
  // sample of a word is ignored: for CPHA=1 that is the leading edge of the
  // word, for CPHA=0 it is the trailing edge after the previous word, and in
  // both cases the freshly loaded MSB must stay on o_miso. The word-end
  // reload happens the cycle after rec_done so data_in may react to it.
  always_comb begin
    tx_d        = tx_q;
    rx_d        = rx_q;
    rec_data_d  = rec_data_q;
    bit_cnt_d   = bit_cnt_q;
    ch_d        = ch_q;
    miso_d      = miso_q;
    rec_done_d  = 1'b0;
    tx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    warm_d      = warm_done ? warm_q : warm_q + WARM_W'(1);
    armed_d     = armed_q | (warm_done & cs_s);
    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        ch_d      = '0;
      end
      LOAD: begin
        if (cs_rise) begin
          miso_d = 1'b0;
          ch_d   = '0;
        end else begin
          tx_d      = tx_src;
          miso_d    = tx_src[DATA_W-1];
          rx_d      = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          frame_err_d = (bit_cnt_q != '0);
          miso_d      = 1'b0;
          bit_cnt_d   = '0;
          ch_d        = '0;
        end else if (rec_done_q) begin
          tx_d   = tx_src;
          miso_d = tx_src[DATA_W-1];
          ch_d   = (ch_q == CH_W'(CH_NUM - 1)) ? '0 : ch_q + CH_W'(1);
        end else if (sample_edge) begin
          rx_d = {rx_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            rec_data_d = rx_d;
            rec_done_d = 1'b1;
            tx_done_d  = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (shift_edge && (bit_cnt_q != '0)) begin
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          miso_d = tx_q[DATA_W-2];
        end
      end
      default: begin
        miso_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_q        <= '0;
      rx_q        <= '0;
      rec_data_q  <= '0;
      bit_cnt_q   <= '0;
      ch_q        <= '0;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      miso_q      <= 1'b0;
      rec_done_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rec_data_q  <= rec_data_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_q        <= ch_d;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      miso_q      <= miso_d;
      rec_done_q  <= rec_done_d;
      tx_done_q   <= tx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_miso        = miso_q;
  assign rec_data      = rec_data_q;
  assign rec_done      = rec_done_q;
  assign transmit_done = tx_done_q;
  assign channel_num   = ch_q;
  assign frame_err     = frame_err_q;

endmodule
